sort_frame_loader: RTL and testbench

- Upstream stage of the 4-input 16-bit descending sorter.
- Accepts a serial stream of words on a valid/ready handshake and packs every 4 consecutive words into a frame.
- Presents each frame as four registered, stable words (a, b, c, d) for the combinational sorter.
- Double-buffered: the next frame fills while the current frame waits on the consumer.

---
 rtl/sort_pkg.sv | 14 +
 rtl/sort_frame_loader.sv | 92 +++++++++
 tb/tb_sort_frame_loader.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sort_pkg.sv
// Shared definitions for the 4-input descending sorter and its upstream
// frame loader.
//   DEFAULT_W   : default data word width (matches the sorter operand width)
//   FRAME_WORDS : number of serial words packed into one sorter frame
//   FILL_CNT_W  : width of the fill counter, which must represent 0..FRAME_WORDS
package sort_pkg;

  localparam int DEFAULT_W   = 16;
  localparam int FRAME_WORDS = 4;
  localparam int FILL_CNT_W  = 3;

  localparam logic [FILL_CNT_W-1:0] FILL_FULL = FILL_CNT_W'(FRAME_WORDS);

endpackage

// File: rtl/sort_frame_loader.sv
// sort_frame_loader: packs a serial valid/ready word stream into frames of
// four words and presents each frame as four registered, stable words for the
// combinational sorter. A fill buffer collects the next frame while the
// current frame waits in the output register for the consumer.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous, active-high reset
//   flush      : synchronous discard of the partially filled (or full) buffer
//   in_valid   : in_data is valid this cycle
//   in_ready   : loader accepts in_data this cycle (registered state only)
//   in_data    : serial input word
//   frm_valid  : a/b/c/d hold a complete frame
//   frm_ready  : consumer takes the frame this cycle
//   a,b,c,d    : frame words in arrival order (a first, d last)
//   fill_level : words currently held in the fill buffer, 0..4
module sort_frame_loader
  import sort_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [W-1:0]          in_data,
  output logic                  frm_valid,
  input  logic                  frm_ready,
  output logic [W-1:0]          a,
  output logic [W-1:0]          b,
  output logic [W-1:0]          c,
  output logic [W-1:0]          d,
  output logic [FILL_CNT_W-1:0] fill_level
);

  logic [W-1:0]          w [FRAME_WORDS];
  logic [FILL_CNT_W-1:0] fill_cnt;
  logic                  full;
  logic                  accept;
  logic                  transfer;
  logic                  drain;

  assign full       = (fill_cnt == FILL_FULL);
  assign in_ready   = !full;
  assign fill_level = fill_cnt;

  // in_ready is low whenever the buffer is full, so accept and transfer
  // are mutually exclusive by construction.
  assign accept   = in_valid && in_ready && !flush;
  assign transfer = full && (!frm_valid || frm_ready) && !flush;
  // Flush leaves the output side alone, so a presented frame still drains.
  assign drain    = frm_valid && frm_ready && !transfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FRAME_WORDS; i++) begin
        w[i] <= '0;
      end
      fill_cnt  <= '0;
      a         <= '0;
      b         <= '0;
      c         <= '0;
      d         <= '0;
      frm_valid <= 1'b0;
    end else begin
      // Output frame register
      if (transfer) begin
        a         <= w[0];
        b         <= w[1];
        c         <= w[2];
        d         <= w[3];
        frm_valid <= 1'b1;
      end else if (drain) begin
        frm_valid <= 1'b0;
      end

      // Fill buffer; flush outranks both transfer and accept
      if (flush || transfer) begin
        fill_cnt <= '0;
      end else if (accept) begin
        for (int i = 0; i < FRAME_WORDS; i++) begin
          if (fill_cnt == FILL_CNT_W'(i)) begin
            w[i] <= in_data;
          end
        end
        fill_cnt <= fill_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sort_frame_loader.sv
// Directed testbench for sort_frame_loader: reset state, basic frame latency,
// backpressure, back-to-back streaming, flush cases and asynchronous reset.
module tb_sort_frame_loader;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          frm_valid;
  logic          frm_ready;
  logic [W-1:0]  a, b, c, d;
  logic [2:0]    fill_level;

  int n_cmp = 0;
  int n_err = 0;

  sort_frame_loader #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .frm_valid  (frm_valid),
    .frm_ready  (frm_ready),
    .a          (a),
    .b          (b),
    .c          (c),
    .d          (d),
    .fill_level (fill_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x);
    in_valid = 1'b1;
    in_data  = x;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    int idx;
    int lows;
    int acc;
    logic [W-1:0] frames [$];

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; frm_ready = 1'b0;
    #1;
    chk("rst_frm_valid", frm_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fill", fill_level, 0);
    chk("rst_a", a, 0);
    chk("rst_d", d, 0);
    tick();
    rst = 1'b0;
    tick();

    // Basic frame
    frm_ready = 1'b1;
    send(16'h0010); send(16'h00A0); send(16'h0005); send(16'hFFFF);
    chk("basic_fill4", fill_level, 4);
    chk("basic_not_ready", in_ready, 0);
    chk("basic_no_frame_yet", frm_valid, 0);
    tick();
    chk("basic_frm_valid", frm_valid, 1);
    chk("basic_a", a, 16'h0010);
    chk("basic_b", b, 16'h00A0);
    chk("basic_c", c, 16'h0005);
    chk("basic_d", d, 16'hFFFF);
    chk("basic_fill0", fill_level, 0);
    tick();
    chk("basic_drained", frm_valid, 0);
    chk("basic_a_retained", a, 16'h0010);

    // Backpressure: 12 words offered, only 8 fit
    frm_ready = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid = 1'b1;
      in_data  = W'(16'h0101 + idx);
      acc = int'(in_ready);
      tick();
      idx += acc;
      if (idx == 12) break;
    end
    in_valid = 1'b0;
    chk("bp_accepted", idx, 8);
    chk("bp_fill4", fill_level, 4);
    chk("bp_not_ready", in_ready, 0);
    chk("bp_frm_valid", frm_valid, 1);
    chk("bp_a_f1", a, 16'h0101);
    chk("bp_d_f1", d, 16'h0104);
    frm_ready = 1'b1;
    tick();
    frm_ready = 1'b0;
    chk("bp_f2_valid", frm_valid, 1);
    chk("bp_f2_a", a, 16'h0105);
    chk("bp_f2_b", b, 16'h0106);
    chk("bp_f2_c", c, 16'h0107);
    chk("bp_f2_d", d, 16'h0108);
    chk("bp_fill0", fill_level, 0);
    tick();
    chk("bp_stable_valid", frm_valid, 1);
    chk("bp_stable_a", a, 16'h0105);
    frm_ready = 1'b1;
    tick();
    chk("bp_drained", frm_valid, 0);

    // Back-to-back streaming of 20 words
    idx = 0;
    lows = 0;
    for (int cyc = 0; cyc < 32; cyc++) begin
      if (frm_valid && frm_ready) begin
        frames.push_back(a); frames.push_back(b);
        frames.push_back(c); frames.push_back(d);
      end
      if (!in_ready) lows++;
      in_valid = (idx < 20);
      in_data  = W'(16'h0200 + idx);
      acc = int'(in_valid && in_ready);
      tick();
      idx += acc;
    end
    in_valid = 1'b0;
    chk("b2b_accepted", idx, 20);
    chk("b2b_in_ready_lows", lows, 5);
    chk("b2b_words_out", frames.size(), 20);
    for (int i = 0; i < frames.size(); i++) begin
      chk($sformatf("b2b_word%0d", i), frames[i], 16'h0200 + i);
    end

    // Flush of a partial frame, with a word offered in the flush cycle
    frm_ready = 1'b0;
    send(16'h0301); send(16'h0302);
    chk("flush_pre_fill", fill_level, 2);
    flush = 1'b1;
    send(16'h1234);
    flush = 1'b0;
    chk("flush_fill0", fill_level, 0);
    send(16'h0401); send(16'h0402); send(16'h0403); send(16'h0404);
    tick();
    chk("flush_frm_valid", frm_valid, 1);
    chk("flush_a", a, 16'h0401);
    chk("flush_b", b, 16'h0402);
    chk("flush_c", c, 16'h0403);
    chk("flush_d", d, 16'h0404);

    // Flush while a frame is presented and not taken
    send(16'h0501); send(16'h0502); send(16'h0503);
    chk("flushp_fill3", fill_level, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flushp_fill0", fill_level, 0);
    chk("flushp_frm_valid", frm_valid, 1);
    chk("flushp_a", a, 16'h0401);
    chk("flushp_d", d, 16'h0404);

    // Asynchronous reset between edges
    send(16'h0601); send(16'h0602);
    chk("arst_pre_fill", fill_level, 2);
    chk("arst_pre_valid", frm_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_frm_valid", frm_valid, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_fill", fill_level, 0);
    chk("arst_a", a, 0);
    tick();
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
